// File: rtl/munoc_resp_packetizer.sv
// ---------------------------------------------------------------------------
// munoc_resp_packetizer
//
// Slave-side response packetizer for the MUNOC fabric. AXI B responses and
// R bursts from a local slave are turned into packets and sent as flits on a
// credit-based link toward the router.
//
// Packet formats. Each packet is left-aligned, zero-padded at the LSBs and
// sent MSB chunk first:
//   B packet : {2'b01, node_id, tid, bresp}    NB flits
//   R header : {2'b10, node_id, tid}           NH flits
//   R beat   : {rlast, rresp, rdata}           ND flits per beat
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   b_valid      in   B response pending
//   b_ready      out  B consumed (on the last B flit)
//   b_info       in   {node_id, tid, bresp}
//   r_valid      in   R beat pending
//   r_ready      out  R beat consumed (on the last flit of the beat)
//   r_info       in   {node_id, tid, rlast, rresp, rdata}
//   link_valid   out  flit valid this cycle
//   link_head    out  first flit of a packet
//   link_tail    out  last flit of a packet
//   link_flit    out  flit payload
//   link_credit  in   one credit returned by the router this cycle
//   link_stall   in   hold the output (test/debug)
//   state        out  FSM state, for debug (IDLE reads 0)
// ---------------------------------------------------------------------------
module munoc_resp_packetizer #(
    parameter int BW_DATA    = 32,
    parameter int BW_FLIT    = 16,
    parameter int BW_NODE_ID = 4,
    parameter int BW_TID     = 4,
    parameter int NUM_CREDIT = 4,
    parameter int RR_ARB     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   b_valid,
    output logic                                   b_ready,
    input  logic [BW_NODE_ID+BW_TID+2-1:0]         b_info,
    input  logic                                   r_valid,
    output logic                                   r_ready,
    input  logic [BW_NODE_ID+BW_TID+3+BW_DATA-1:0] r_info,
    output logic                                   link_valid,
    output logic                                   link_head,
    output logic                                   link_tail,
    output logic [BW_FLIT-1:0]                     link_flit,
    input  logic                                   link_credit,
    input  logic                                   link_stall,
    output logic [1:0]                             state
);

    // Packet widths and flit counts.
    localparam int NT_W  = BW_NODE_ID + BW_TID;
    localparam int RI_W  = NT_W + 3 + BW_DATA;
    localparam int WB    = NT_W + 4;
    localparam int WH    = NT_W + 2;
    localparam int WD    = BW_DATA + 3;
    localparam int NB    = (WB + BW_FLIT - 1) / BW_FLIT;
    localparam int NH    = (WH + BW_FLIT - 1) / BW_FLIT;
    localparam int ND    = (WD + BW_FLIT - 1) / BW_FLIT;
    localparam int MAXN  = (NB > NH) ? ((NB > ND) ? NB : ND) : ((NH > ND) ? NH : ND);
    localparam int PKT_W = MAXN * BW_FLIT;
    localparam int IDX_W = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int CRED_W = $clog2(NUM_CREDIT + 1);

    localparam logic [IDX_W-1:0]  B_LAST   = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0]  H_LAST   = IDX_W'(NH - 1);
    localparam logic [IDX_W-1:0]  D_LAST   = IDX_W'(ND - 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(NUM_CREDIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_SEND = 2'd1,
        R_HDR  = 2'd2,
        R_DATA = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CRED_W-1:0]   credit_q, credit_d;
    // 1 when R held the most recent grant, 0 when B did.
    logic                last_r_q, last_r_d;

    logic                sending_st;
    logic                send;
    logic                is_last;
    logic                rlast;
    logic [PKT_W-1:0]    b_vec;
    logic [PKT_W-1:0]    h_vec;
    logic [PKT_W-1:0]    d_vec;
    logic [PKT_W-1:0]    sel_vec;
    logic [PKT_W-1:0]    sel_shift;

    assign rlast = r_info[BW_DATA+2];

    // Left-align every packet in a common vector so one shifter serves all
    // three formats; the current flit is always the top BW_FLIT bits.
    always_comb begin
        b_vec = '0;
        h_vec = '0;
        d_vec = '0;
        b_vec[PKT_W-1 -: WB] = {2'b01, b_info};
        h_vec[PKT_W-1 -: WH] = {2'b10, r_info[RI_W-1 -: NT_W]};
        d_vec[PKT_W-1 -: WD] = r_info[WD-1:0];
        case (state_q)
            B_SEND:  sel_vec = b_vec;
            R_HDR:   sel_vec = h_vec;
            R_DATA:  sel_vec = d_vec;
            default: sel_vec = '0;
        endcase
        sel_shift = sel_vec << (int'(idx_q) * BW_FLIT);
    end

    // Send qualification. Between beats of a burst the FSM sits in R_DATA
    // and waits for r_valid without emitting anything.
    always_comb begin
        sending_st = (state_q == B_SEND) || (state_q == R_HDR) ||
                     ((state_q == R_DATA) && r_valid);
        send       = sending_st && (credit_q != '0) && !link_stall;
        case (state_q)
            B_SEND:  is_last = (idx_q == B_LAST);
            R_HDR:   is_last = (idx_q == H_LAST);
            R_DATA:  is_last = (idx_q == D_LAST);
            default: is_last = 1'b0;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_r_d  = last_r_q;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        link_tail = 1'b0;
        link_head = 1'b0;

        case (state_q)
            IDLE: begin
                // With both pending, B wins unless round-robin is enabled and
                // B took the previous grant.
                if (b_valid && (!r_valid || (RR_ARB == 0) || last_r_q)) begin
                    state_d  = B_SEND;
                    last_r_d = 1'b0;
                end else if (r_valid) begin
                    state_d  = R_HDR;
                    last_r_d = 1'b1;
                end
            end
            B_SEND: begin
                if (send) begin
                    link_head = (idx_q == '0);
                    if (is_last) begin
                        link_tail = 1'b1;
                        b_ready   = 1'b1;
                        idx_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            R_HDR: begin
                if (send) begin
                    link_head = (idx_q == '0);
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = R_DATA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (send) begin
                    if (is_last) begin
                        r_ready = 1'b1;
                        idx_d   = '0;
                        if (rlast) begin
                            link_tail = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Credit counter: a send and a returned credit in the same cycle cancel.
    always_comb begin
        credit_d = credit_q;
        case ({send, link_credit})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   if (credit_q != CRED_MAX) credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    assign link_valid = send;
    assign link_flit  = send ? sel_shift[PKT_W-1 -: BW_FLIT] : '0;
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            credit_q <= CRED_MAX;
            last_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            last_r_q <= last_r_d;
        end
    end

    // The router can never hold more credits than it has buffer slots.
    credit_overflow_a : assert property (@(posedge clk) disable iff (rst)
        !(link_credit && !send && (credit_q == CRED_MAX)));

endmodule
